// File: rtl/data_receiver.sv
// Receive end of the three-wire serial link: synchronises frame, bit clock and data,
// then reassembles eight LSB-first bytes into one 64-bit word.
module data_receiver #(
  parameter int TIMEOUT   = 100000,
  parameter int TIMEOUT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transmission,
  input  logic        clock,
  input  logic        in_data,
  output logic [63:0] data,
  output logic        valid,
  output logic        error,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BYTE, GAP} state_t;

  state_t state_q, state_d;

  logic tr_s1, tr_s2, tr_prev;
  logic sck_s1, sck_s2, sck_prev;
  logic din_s1, din_s2;
  logic [1:0] sync_fill;
  logic armed;

  logic tr_rise_q, tr_fall_q, bit_stb_q, bit_val_q;

  logic [7:0]           shreg;
  logic [3:0]           bit_cnt;
  logic [2:0]           byte_idx;
  logic [6:0][7:0]      asm_buf;
  logic [TIMEOUT_W-1:0] gap_cnt;

  logic valid_d, error_d, byte_done, word_done;

  // A frame level already high out of reset must not look like a rising edge,
  // so rises only count once the synchronised line has been seen low.
  always_ff @(posedge clk) begin
    if (rst) begin
      {tr_s1, tr_s2, tr_prev}    <= '0;
      {sck_s1, sck_s2, sck_prev} <= '0;
      {din_s1, din_s2}           <= '0;
      sync_fill                  <= '0;
      armed                      <= 1'b0;
      tr_rise_q                  <= 1'b0;
      tr_fall_q                  <= 1'b0;
      bit_stb_q                  <= 1'b0;
      bit_val_q                  <= 1'b0;
    end else begin
      tr_s1     <= transmission;
      tr_s2     <= tr_s1;
      tr_prev   <= tr_s2;
      sck_s1    <= clock;
      sck_s2    <= sck_s1;
      sck_prev  <= sck_s2;
      din_s1    <= in_data;
      din_s2    <= din_s1;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & ~tr_s2);
      // Edge strobes are registered once so the word appears three cycles after the pin falls.
      tr_rise_q <= tr_s2 & ~tr_prev & armed;
      tr_fall_q <= ~tr_s2 & tr_prev;
      bit_stb_q <= sck_s2 & ~sck_prev & tr_s2;
      bit_val_q <= din_s2;
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    byte_done = 1'b0;
    word_done = 1'b0;
    case (state_q)
      IDLE: if (tr_rise_q) state_d = BYTE;
      BYTE: begin
        if (tr_fall_q) begin
          state_d = IDLE;
          if (bit_cnt == 4'd8) begin
            if (byte_idx == 3'd7) begin
              word_done = 1'b1;
              valid_d   = 1'b1;
            end else begin
              byte_done = 1'b1;
              state_d   = GAP;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (tr_rise_q) begin
          state_d = BYTE;
        end else if (gap_cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid    <= 1'b0;
      error    <= 1'b0;
      data     <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      asm_buf  <= '0;
      gap_cnt  <= '0;
    end else begin
      state_q <= state_d;
      valid   <= valid_d;
      error   <= error_d;
      case (state_q)
        IDLE: begin
          if (tr_rise_q) begin
            bit_cnt  <= '0;
            byte_idx <= '0;
          end
        end
        BYTE: begin
          if (bit_stb_q) begin
            shreg <= {bit_val_q, shreg[7:1]};
            if (bit_cnt != 4'd15) bit_cnt <= bit_cnt + 4'd1;
          end
          if (byte_done) begin
            asm_buf[byte_idx] <= shreg;
            byte_idx          <= byte_idx + 3'd1;
            gap_cnt           <= '0;
          end
          if (word_done) data <= {shreg, asm_buf};
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (tr_rise_q) bit_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_data_receiver.sv
// Directed bench for data_receiver: words, malformed bytes, gap timeout, reset cases
// and pin-to-valid latency, checked with immediate assertions.
module tb_data_receiver;

  localparam int TO = 200;
  localparam int HP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        transmission = 1'b0;
  logic        clock = 1'b0;
  logic        in_data = 1'b0;
  logic [63:0] data;
  logic        valid, error, busy;

  int tests = 0;
  int fails = 0;
  int vcount = 0, ecount = 0, both = 0;

  data_receiver #(.TIMEOUT(TO), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst(rst), .transmission(transmission), .clock(clock),
    .in_data(in_data), .data(data), .valid(valid), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    vcount <= vcount + int'(valid);
    ecount <= ecount + int'(error);
    both   <= both + int'(valid & error);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits, input bit drop);
    transmission = 1'b1;
    wait_clks(HP);
    for (int i = 0; i < nbits; i++) begin
      in_data = (i < 8) ? b[i] : 1'b0;
      clock = 1'b0;
      wait_clks(HP);
      clock = 1'b1;
      wait_clks(HP);
    end
    clock = 1'b0;
    wait_clks(HP);
    if (drop) transmission = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input int gap);
    for (int k = 0; k < 8; k++) begin
      send_byte(w[8*k +: 8], 8, 1'b1);
      if (k < 7) wait_clks(gap);
    end
    wait_clks(6);
  endtask

  initial begin
    int v0, e0, n;
    bit seen;

    wait_clks(5);
    rst = 1'b0;
    wait_clks(1);
    chk("reset_data", data, 64'h0);
    chk("reset_valid", {63'h0, valid}, 64'h0);
    chk("reset_error", {63'h0, error}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    wait_clks(5);

    // Word 1 with exact pin-to-valid latency on byte 7.
    v0 = vcount; e0 = ecount;
    for (int k = 0; k < 7; k++) begin
      send_byte(8'(64'h0123456789ABCDEF >> (8*k)), 8, 1'b1);
      wait_clks(50);
    end
    send_byte(8'h01, 8, 1'b0);
    chk("busy_mid_word", {63'h0, busy}, 64'h1);
    transmission = 1'b0;
    wait_clks(3);
    chk("valid_not_at_2", {63'h0, valid}, 64'h0);
    wait_clks(1);
    chk("valid_at_3", {63'h0, valid}, 64'h1);
    chk("busy_drops_with_valid", {63'h0, busy}, 64'h0);
    chk("word1_data", data, 64'h0123456789ABCDEF);
    wait_clks(1);
    chk("valid_one_cycle", {63'h0, valid}, 64'h0);
    wait_clks(3);
    chk("word1_vcount", 64'(vcount - v0), 64'd1);
    chk("word1_ecount", 64'(ecount - e0), 64'd0);

    // Back-to-back words.
    v0 = vcount; e0 = ecount;
    send_word(64'hFFFFFFFFFFFFFFFF, 50);
    chk("ones_data", data, 64'hFFFFFFFFFFFFFFFF);
    wait_clks(20);
    send_word(64'h0, 50);
    chk("zero_data", data, 64'h0);
    chk("b2b_vcount", 64'(vcount - v0), 64'd2);
    chk("b2b_ecount", 64'(ecount - e0), 64'd0);

    // Byte 3 short by one bit.
    wait_clks(20);
    v0 = vcount; e0 = ecount;
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h5A, 8, 1'b1);
      wait_clks(50);
    end
    send_byte(8'h5A, 7, 1'b1);
    wait_clks(6);
    chk("short_ecount", 64'(ecount - e0), 64'd1);
    chk("short_vcount", 64'(vcount - v0), 64'd0);
    chk("short_busy", {63'h0, busy}, 64'h0);
    chk("short_data_kept", data, 64'h0);
    wait_clks(20);
    send_word(64'hA5A5A5A5A5A5A5A5, 50);
    chk("a5_data", data, 64'hA5A5A5A5A5A5A5A5);
    chk("a5_vcount", 64'(vcount - v0), 64'd1);

    // Gap timeout: error at the 204th negedge after the pin falls (3 sync/edge + 200 gap).
    wait_clks(20);
    v0 = vcount; e0 = ecount;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) wait_clks(50);
      send_byte(8'h11, 8, 1'b1);
    end
    n = 0; seen = 1'b0;
    for (int i = 1; i <= 400 && !seen; i++) begin
      wait_clks(1);
      if (error) begin n = i; seen = 1'b1; end
    end
    chk("timeout_cycles", 64'(n), 64'd204);
    wait_clks(2);
    chk("timeout_busy", {63'h0, busy}, 64'h0);
    chk("timeout_data_kept", data, 64'hA5A5A5A5A5A5A5A5);
    chk("timeout_ecount", 64'(ecount - e0), 64'd1);
    chk("timeout_vcount", 64'(vcount - v0), 64'd0);

    // Reset after four bytes, then a clean word.
    wait_clks(20);
    for (int k = 0; k < 4; k++) begin
      send_byte(8'h77, 8, 1'b1);
      wait_clks(50);
    end
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    chk("rst_mid_data", data, 64'h0);
    wait_clks(5);
    v0 = vcount; e0 = ecount;
    send_word(64'h1122334455667788, 50);
    chk("after_rst_data", data, 64'h1122334455667788);
    chk("after_rst_vcount", 64'(vcount - v0), 64'd1);
    chk("after_rst_ecount", 64'(ecount - e0), 64'd0);

    // Frame line already high when reset releases: ignored.
    transmission = 1'b1;
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(10);
    v0 = vcount; e0 = ecount;
    send_byte(8'hFF, 8, 1'b0);
    chk("stuck_high_busy", {63'h0, busy}, 64'h0);
    transmission = 1'b0;
    wait_clks(10);
    chk("stuck_high_ecount", 64'(ecount - e0), 64'd0);
    chk("stuck_high_data", data, 64'h0);
    send_word(64'hDEADBEEF00C0FFEE, 50);
    chk("post_stuck_data", data, 64'hDEADBEEF00C0FFEE);
    chk("post_stuck_vcount", 64'(vcount - v0), 64'd1);
    chk("valid_error_exclusive", 64'(both), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_receiver.md
Name: data_receiver

Overview:
- Receive end of the three-wire link driven by the team's 64-bit data transmitter.
- Inputs are the `transmission` frame line, the serial `clock` line and `in_data`, all asynchronous to `clk`.
- The block synchronises the lines, shifts in 8 bytes of 8 bits each and reassembles the 64-bit word.
- It presents the word with a one-cycle `valid` pulse, and flags malformed bytes or stalled words on `error`.

Parameters:
- TIMEOUT, 100000: max clk cycles allowed between the end of one byte and the start of the next inside a word before the word is aborted.
- TIMEOUT_W, 32: width of the gap counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- transmission  input  1  byte frame; high while one byte is on the wire; async.
- clock  input  1  serial bit clock from the transmitter; async.
- in_data  input  1  serial data; async.
- data  output  64  last complete word; byte k occupies data[8k+7:8k].
- valid  output  1  one-cycle pulse when `data` updates.
- error  output  1  one-cycle pulse when a byte or word is discarded.
- busy  output  1  high while a word is partially received (state != IDLE).

Behaviour:
- Reset is synchronous and active-high. On reset:
  - data=0, valid=0, error=0, busy=0.
  - state=IDLE; bit_cnt, byte_idx and gap counter = 0.
  - All synchroniser flops = 0.
- Synchronisation:
  - `transmission`, `clock` and `in_data` each pass through a 2-flop synchroniser, plus a third "previous" flop for edge detection.
  - Data is sampled from the synchronised stage, so it stays aligned with the synchronised clock.
- Wire protocol:
  - A bit is captured on each synchronised rising edge of `clock` while synchronised `transmission` is high.
  - Bits arrive LSB first; the shift register shifts right and the new bit enters at bit 7.
  - Bytes arrive in order byte 0 first, byte 7 last.
  - The line must hold each half-period of `clock` for at least 3 clk cycles; faster input is out of spec.
- States:
  - IDLE: wait for a synchronised rising edge of `transmission` -> BYTE. Clear bit_cnt; byte_idx=0.
  - BYTE: count captured bits. bit_cnt saturates at 15; extra bits still count toward the error check. Action on synchronised falling edge of `transmission`:
    - bit_cnt==8 and byte_idx<7: store the byte into the assembly buffer slot byte_idx; byte_idx++; clear gap counter -> GAP.
    - bit_cnt==8 and byte_idx==7: data <= {byte7..byte0} in the same cycle; valid=1 for one cycle -> IDLE.
    - bit_cnt!=8 (short or long byte): error=1 for one cycle; discard the partial word; data unchanged -> IDLE.
  - GAP:
    - Increment the gap counter each cycle.
    - Rising edge of `transmission` -> BYTE, bit_cnt=0.
    - Counter reaches TIMEOUT-1 with no rising edge: error=1 for one cycle -> IDLE.
- Latency: `valid` is high exactly 3 clk cycles after the first clk edge that samples the `transmission` pin low at the end of byte 7.
- Edge cases and precedence:
  - A `clock` edge coinciding with the `transmission` fall is not captured.
  - `valid` and `error` are never high in the same cycle.
  - `data` holds its value until the next complete word; it is not cleared by errors.
  - Reset mid-word: the partial word is lost and no `error` pulse is produced; the next frame starts clean.
  - A `transmission` high level present when reset releases is not a rising edge. The frame is ignored until the line returns low and then rises again.
- Size: roughly 150-250 lines of RTL.

Test Plan:
- Single word 0x0123456789ABCDEF, LSB-first bytes starting 0xEF, 8-clk half-periods, 50-cycle inter-byte gaps -> exactly one valid pulse; data=0x0123456789ABCDEF; error never high; busy drops with valid.
- Two back-to-back words 0xFFFFFFFFFFFFFFFF then 0x0 -> two valid pulses; data ends at 0x0; no error.
- Byte 3 sent with 7 bits -> error pulse at its frame end; no valid. A following correct word 0xA5A5A5A5A5A5A5A5 is received intact.
- TIMEOUT=200, five bytes sent then the line goes silent -> error pulse 200 cycles after byte 4 ends; busy=0; data keeps its previous value.
- rst asserted after 4 bytes, then a full word 0x1122334455667788 -> no error, one valid; data=0x1122334455667788.
- Pin-level timing check: `transmission` falls at the end of byte 7 -> valid high exactly 3 clk later.
